// File: rtl/burst_mem_model.sv
// Burst-line memory model: one line per request, fixed read/write latency, address window check.
// Optional: define MEM_ADDR_ERR_EN to pulse o_err in the response cycle of an out-of-window access.
module burst_mem_model #(
    parameter int BIT_W      = 32,
    parameter int LINE_WORDS = 4,
    parameter int SIZE       = 4096,
    parameter int ADDR_W     = 32,
    parameter int RD_LAT     = 10,
    parameter int WR_LAT     = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cen,
    input  logic                          i_wen,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [BIT_W*LINE_WORDS-1:0]   i_wdata,
    input  logic [LINE_WORDS-1:0]         i_wmask,
    output logic [BIT_W*LINE_WORDS-1:0]   o_rdata,
    output logic                          o_stall,
    output logic                          o_err,
    input  logic [ADDR_W-1:0]             i_offset,
    input  logic [ADDR_W-1:0]             i_ubound
);

    localparam int LINE_W  = BIT_W * LINE_WORDS;
    localparam int LINES   = SIZE / LINE_WORDS;
    localparam int IDX_W   = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int SHIFT   = $clog2(BIT_W / 8) + $clog2(LINE_WORDS);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_C = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] WR_C = CNT_W'(WR_LAT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  wen_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [LINE_W-1:0]     wdata_q;
    logic [LINE_WORDS-1:0] wmask_q;
    logic [LINE_W-1:0]     mem [LINES];

    logic [ADDR_W:0]       diff;
    logic [ADDR_W-1:0]     line_full;
    logic [IDX_W-1:0]      idx;
    logic                  addr_ok;
    logic                  resp;
    logic [CNT_W-1:0]      lat;

    // The extra borrow bit of diff flags addresses below the window; lines past the
    // end of storage are also rejected so a wide window can never alias a real line.
    always_comb begin
        diff      = {1'b0, addr_q} - {1'b0, i_offset};
        line_full = diff[ADDR_W-1:0] >> SHIFT;
        idx       = line_full[IDX_W-1:0];
        addr_ok   = !diff[ADDR_W] && (addr_q < i_ubound) && (line_full < ADDR_W'(LINES));
        lat       = wen_q ? WR_C : RD_C;
        resp      = (state == BUSY) && (cnt == lat);
    end

    always_comb begin
        o_stall = 1'b0;
        o_rdata = '0;
        o_err   = 1'b0;
        if (i_rst_n) begin
            o_stall = (state == IDLE) ? i_cen : !resp;
            if (resp && !wen_q && addr_ok)
                o_rdata = mem[idx];
`ifdef MEM_ADDR_ERR_EN
            o_err = resp && !addr_ok;
`else
            o_err = 1'b0;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            for (int i = 0; i < LINES; i++)
                mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cen) begin
                        wen_q   <= i_wen;
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        wmask_q <= i_wmask;
                        cnt     <= CNT_W'(1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (resp) begin
                        if (wen_q && addr_ok) begin
                            for (int w = 0; w < LINE_WORDS; w++)
                                if (wmask_q[w])
                                    mem[idx][w*BIT_W +: BIT_W] <= wdata_q[w*BIT_W +: BIT_W];
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
